// File: rtl/nn_pkg.sv
// Shared types and constants for the time-multiplexed neuron layer.
package nn_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned NUM_NEURONS_DEF = 4;

  localparam logic CFG_SEL_WEIGHT = 1'b0;
  localparam logic CFG_SEL_BIAS   = 1'b1;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Sample-in / result-out valid/ready streams of the layer sequencer.
interface neuron_layer_sequencer_if
  import nn_pkg::*;
#(
  parameter int unsigned IDX_W = 2
);
  logic             in_valid;
  logic             in_ready;
  data_t            in_data;
  logic             out_valid;
  logic             out_ready;
  data_t            out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  // master: the environment feeding samples and consuming results
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  // slave: the sequencer itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/neuron_param_regfile.sv
// Per-neuron weight/bias storage; writable only while the sequencer is idle.
module neuron_param_regfile
  import nn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int unsigned IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [IDX_W-1:0] cfg_addr,
  input  data_t            cfg_data,
  input  logic [IDX_W-1:0] rd_idx,
  output data_t            rd_w_c,
  output data_t            rd_b_c
);

  data_t w_q [NUM_NEURONS];
  data_t b_q [NUM_NEURONS];
  data_t w_d [NUM_NEURONS];
  data_t b_d [NUM_NEURONS];

  logic wr_ok_c;

  // Out-of-range addresses only occur when NUM_NEURONS is not a power of two
  assign wr_ok_c = wr_en && cfg_we && (32'(cfg_addr) < NUM_NEURONS);

  always_comb begin
    w_d = w_q;
    b_d = b_q;
    if (wr_ok_c) begin
      if (cfg_sel == CFG_SEL_BIAS) b_d[cfg_addr] = cfg_data;
      else                         w_d[cfg_addr] = cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_NEURONS); i++) begin
        w_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      w_q <= w_d;
      b_q <= b_d;
    end
  end

  assign rd_w_c = w_q[rd_idx];
  assign rd_b_c = b_q[rd_idx];

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Steps one combinational neuron across NUM_NEURONS outputs per input sample,
// capturing each result into a held valid/ready output stream.
module neuron_layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int unsigned IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic                     cfg_sel,
  input  logic [IDX_W-1:0]         cfg_addr,
  input  data_t                    cfg_data,
  neuron_layer_sequencer_if.slave  io,
  output data_t                    nrn_x1,
  output data_t                    nrn_w1,
  output data_t                    nrn_b,
  input  data_t                    nrn_f
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  seq_state_e       state_q,     state_d;
  data_t            x_q,         x_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  data_t            out_data_q,  out_data_d;
  logic [IDX_W-1:0] out_idx_q,   out_idx_d;
  logic             out_last_q,  out_last_d;

  neuron_param_regfile #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W)
  ) u_params (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (state_q == ST_IDLE),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .rd_idx   (idx_q),
    .rd_w_c   (nrn_w1),
    .rd_b_c   (nrn_b)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          x_d     = io.in_data;
          idx_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        out_data_d  = nrn_f;
        out_idx_d   = idx_q;
        out_last_d  = (idx_q == LAST_IDX);
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_CALC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // in_ready is a pure decode of the next state, so it can be a flop
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign nrn_x1       = x_q;
  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_idx   = out_idx_q;
  assign io.out_last  = out_last_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with a behavioural 1-input ReLU neuron.
module tb_neuron_layer_sequencer;
  import nn_pkg::*;

  localparam int unsigned NN = 4;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [31:0]      x;
    logic [7:0]       stall;
    logic [3:0][31:0] exp;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic          cfg_sel;
  logic [IW-1:0] cfg_addr;
  logic [31:0]   cfg_data;
  logic [31:0]   nrn_x1, nrn_w1, nrn_b, nrn_f;

  int checks;
  int errors;
  int rdy_low;

  neuron_layer_sequencer_if #(.IDX_W(IW)) sif ();

  neuron_layer_sequencer #(.NUM_NEURONS(NN), .IDX_W(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .io       (sif),
    .nrn_x1   (nrn_x1),
    .nrn_w1   (nrn_w1),
    .nrn_b    (nrn_b),
    .nrn_f    (nrn_f)
  );

  function automatic logic [31:0] neuron(input logic signed [31:0] x, w, b);
    logic signed [31:0] s;
    s = x * w + b;
    return (s < 0) ? 32'd0 : s;
  endfunction

  assign nrn_f = neuron(nrn_x1, nrn_w1, nrn_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!sif.in_ready) rdy_low++;
  endtask

  task automatic cfg_write(input logic sel, input logic [IW-1:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] x);
    int n = 0;
    while (!sif.in_ready && n < 50) begin tick(); n++; end
    chk("in_ready before accept", 32'(sif.in_ready), 32'd1);
    sif.in_valid = 1'b1;
    sif.in_data  = x;
    tick();
    sif.in_valid = 1'b0;
  endtask

  task automatic collect(input logic [3:0][31:0] exp, input int stall, input string tag);
    for (int i = 0; i < int'(NN); i++) begin
      int n = 0;
      while (!sif.out_valid && n < 20) begin tick(); n++; end
      chk({tag, " out_valid"}, 32'(sif.out_valid), 32'd1);
      chk({tag, " out_data"},  sif.out_data, exp[i]);
      chk({tag, " out_idx"},   32'(sif.out_idx), 32'(i));
      chk({tag, " out_last"},  32'(sif.out_last), 32'(i == int'(NN) - 1));
      for (int s = 0; s < stall; s++) begin
        tick();
        chk({tag, " stall valid"}, 32'(sif.out_valid), 32'd1);
        chk({tag, " stall data"},  sif.out_data, exp[i]);
        chk({tag, " stall idx"},   32'(sif.out_idx), 32'(i));
      end
      sif.out_ready = 1'b1;
      tick();
      chk({tag, " valid drop"}, 32'(sif.out_valid), 32'd0);
      if (stall > 0) sif.out_ready = 1'b0;
    end
  endtask

  vec_t vecs [2];

  initial begin
    checks = 0; errors = 0; rdy_low = 0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b0;

    vecs[0].x = 32'd3;          vecs[0].stall = 8'd0;
    vecs[0].exp[0] = 32'd1;     vecs[0].exp[1] = 32'd1;
    vecs[0].exp[2] = 32'd9;     vecs[0].exp[3] = 32'd7;
    vecs[1].x = -32'sd4;        vecs[1].stall = 8'd5;
    vecs[1].exp[0] = 32'd0;     vecs[1].exp[1] = 32'd8;
    vecs[1].exp[2] = 32'd0;     vecs[1].exp[3] = 32'd7;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst out_valid", 32'(sif.out_valid), 32'd0);
    chk("rst out_data",  sif.out_data, 32'd0);
    chk("rst out_idx",   32'(sif.out_idx), 32'd0);
    chk("rst out_last",  32'(sif.out_last), 32'd0);
    chk("rst nrn_x1",    nrn_x1, 32'd0);
    chk("rst nrn_w1",    nrn_w1, 32'd0);
    chk("rst nrn_b",     nrn_b, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("in_ready after reset", 32'(sif.in_ready), 32'd1);

    // w = {2,-1,3,0}, b = {-5,4,0,7}
    cfg_write(CFG_SEL_WEIGHT, 2'd0, 32'd2);
    cfg_write(CFG_SEL_WEIGHT, 2'd1, -32'sd1);
    cfg_write(CFG_SEL_WEIGHT, 2'd2, 32'd3);
    cfg_write(CFG_SEL_WEIGHT, 2'd3, 32'd0);
    cfg_write(CFG_SEL_BIAS,   2'd0, -32'sd5);
    cfg_write(CFG_SEL_BIAS,   2'd1, 32'd4);
    cfg_write(CFG_SEL_BIAS,   2'd2, 32'd0);
    cfg_write(CFG_SEL_BIAS,   2'd3, 32'd7);

    for (int v = 0; v < 2; v++) begin
      sif.out_ready = (vecs[v].stall == 8'd0);
      rdy_low = 0;
      send(vecs[v].x);
      collect(vecs[v].exp, int'(vecs[v].stall), $sformatf("vec%0d", v));
      if (v == 0) chk("in_ready low cycles", 32'(rdy_low), 32'd8);
      chk("in_ready after layer", 32'(sif.in_ready), 32'd1);
    end

    // Sample held valid through the layer must wait for the last handshake
    sif.out_ready = 1'b1;
    send(32'd3);
    sif.in_valid = 1'b1;
    sif.in_data  = 32'd5;
    collect({32'd7, 32'd9, 32'd1, 32'd1}, 0, "b2b first");
    tick();
    sif.in_valid = 1'b0;
    collect({32'd7, 32'd15, 32'd0, 32'd5}, 0, "b2b second");

    // Weight write during CALC is dropped
    send(32'd1);
    cfg_we = 1'b1; cfg_sel = CFG_SEL_WEIGHT; cfg_addr = 2'd1; cfg_data = 32'd100;
    tick();
    cfg_we = 1'b0;
    collect({32'd7, 32'd3, 32'd3, 32'd0}, 0, "calc wr");
    send(32'd1);
    collect({32'd7, 32'd3, 32'd3, 32'd0}, 0, "after drop");

    // Write in the same IDLE cycle as the accept is used for that sample
    cfg_we = 1'b1; cfg_sel = CFG_SEL_WEIGHT; cfg_addr = 2'd1; cfg_data = 32'd100;
    send(32'd1);
    cfg_we = 1'b0;
    collect({32'd7, 32'd3, 32'd104, 32'd0}, 0, "idle wr");

    // 0x10000 * 0x10000 truncates to zero
    cfg_write(CFG_SEL_WEIGHT, 2'd0, 32'h0001_0000);
    cfg_write(CFG_SEL_BIAS,   2'd0, 32'd1);
    send(32'h0001_0000);
    collect({32'd7, 32'd196608, 32'd6553604, 32'd1}, 0, "trunc");

    // Asynchronous reset while holding idx 2
    send(32'd3);
    begin
      int n = 0;
      while (!(sif.out_valid && sif.out_idx == 2'd2) && n < 20) begin tick(); n++; end
    end
    sif.out_ready = 1'b0;
    chk("pre-reset idx", 32'(sif.out_idx), 32'd2);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(sif.out_valid), 32'd0);
    chk("midrst out_data",  sif.out_data, 32'd0);
    chk("midrst out_idx",   32'(sif.out_idx), 32'd0);
    chk("midrst out_last",  32'(sif.out_last), 32'd0);
    chk("midrst nrn_w1",    nrn_w1, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("in_ready after midrst", 32'(sif.in_ready), 32'd1);
    sif.out_ready = 1'b1;
    send(32'd5);
    collect({32'd0, 32'd0, 32'd0, 32'd0}, 0, "cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
